// File: rtl/step_scan_ctrl.sv
// Stepped DAC scan sequencer: per step writes DAC address and code, waits for settling,
// runs the external counter, then snapshots counter values for readout. STEP_TIMEOUT_EN adds a RUN watchdog.
module step_scan_ctrl #(
  parameter logic [7:0]  DAC_ADDR       = 8'h01,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [7:0]  cfg_first_code,
  input  logic [7:0]  cfg_step,
  input  logic [7:0]  cfg_nsteps,
  input  logic [15:0] cfg_settle,
  input  logic        stop_step,
  input  logic [31:0] time_count,
  input  logic [31:0] ch1_count,
  input  logic [31:0] ch2_count,
  input  logic [31:0] ch3_count,
  input  logic [31:0] ch4_count,
  output logic [7:0]  dac_addr,
  output logic [7:0]  dac_wdata,
  output logic        addr_write,
  output logic        swrite,
  output logic        start_step,
  output logic        cread,
  input  logic [2:0]  snap_sel,
  output logic [31:0] snap_data,
  output logic        snap_valid,
  input  logic        snap_ack,
  output logic        busy,
  output logic        done,
  output logic [7:0]  step_idx,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_DATA   = 4'd2,
    S_SETTLE = 4'd3,
    S_RUN    = 4'd4,
    S_LATCH  = 4'd5,
    S_CAPT   = 4'd6,
    S_HOLD   = 4'd7,
    S_NEXT   = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  nsteps_q, nsteps_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]  step_idx_q, step_idx_d;
  logic        run_armed_q, run_armed_d;
  logic [31:0] snap_time_q, snap_time_d;
  logic [31:0] snap_ch1_q, snap_ch1_d;
  logic [31:0] snap_ch2_q, snap_ch2_d;
  logic [31:0] snap_ch3_q, snap_ch3_d;
  logic [31:0] snap_ch4_q, snap_ch4_d;
`ifdef STEP_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      code_q       <= 8'h00;
      step_q       <= 8'h00;
      nsteps_q     <= 8'h00;
      settle_q     <= 16'h0000;
      settle_cnt_q <= 16'h0000;
      step_idx_q   <= 8'h00;
      run_armed_q  <= 1'b0;
      snap_time_q  <= 32'h0;
      snap_ch1_q   <= 32'h0;
      snap_ch2_q   <= 32'h0;
      snap_ch3_q   <= 32'h0;
      snap_ch4_q   <= 32'h0;
`ifdef STEP_TIMEOUT_EN
      run_cnt_q     <= 32'h0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      step_q       <= step_d;
      nsteps_q     <= nsteps_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      step_idx_q   <= step_idx_d;
      run_armed_q  <= run_armed_d;
      snap_time_q  <= snap_time_d;
      snap_ch1_q   <= snap_ch1_d;
      snap_ch2_q   <= snap_ch2_d;
      snap_ch3_q   <= snap_ch3_d;
      snap_ch4_q   <= snap_ch4_d;
`ifdef STEP_TIMEOUT_EN
      run_cnt_q     <= run_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    step_d       = step_q;
    nsteps_d     = nsteps_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    step_idx_d   = step_idx_q;
    run_armed_d  = run_armed_q;
    snap_time_d  = snap_time_q;
    snap_ch1_d   = snap_ch1_q;
    snap_ch2_d   = snap_ch2_q;
    snap_ch3_d   = snap_ch3_q;
    snap_ch4_d   = snap_ch4_q;
`ifdef STEP_TIMEOUT_EN
    run_cnt_d     = run_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    // Abort wins over everything else, including a same-cycle ack or stop.
    if (state_q != S_IDLE && cfg_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            code_d     = cfg_first_code;
            step_d     = cfg_step;
            nsteps_d   = cfg_nsteps;
            settle_d   = cfg_settle;
            step_idx_d = 8'h00;
`ifdef STEP_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
            state_d = (cfg_nsteps == 8'h00) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: state_d = S_DATA;
        S_DATA: begin
          settle_cnt_d = 16'h0000;
          run_armed_d  = 1'b0;
`ifdef STEP_TIMEOUT_EN
          run_cnt_d = 32'h0;
`endif
          state_d = (settle_q == 16'h0000) ? S_RUN : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_q == settle_q - 16'd1) begin
            state_d = S_RUN;
          end else begin
            settle_cnt_d = settle_cnt_q + 16'd1;
          end
        end
        S_RUN: begin
          // The counter may still show the previous step's stop on the first cycle.
          run_armed_d = 1'b1;
          if (run_armed_q && stop_step) begin
            state_d = S_LATCH;
          end
`ifdef STEP_TIMEOUT_EN
          else if (run_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + 32'd1;
          end
`endif
        end
        S_LATCH: state_d = S_CAPT;
        S_CAPT: begin
          snap_time_d = time_count;
          snap_ch1_d  = ch1_count;
          snap_ch2_d  = ch2_count;
          snap_ch3_d  = ch3_count;
          snap_ch4_d  = ch4_count;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          if (snap_ack) begin
            step_idx_d = step_idx_q + 8'd1;
            state_d    = S_NEXT;
          end
        end
        S_NEXT: begin
          if (step_idx_q == nsteps_q) begin
            state_d = S_DONE;
          end else begin
            code_d  = code_q + step_q;
            state_d = S_ADDR;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_write = (state_q == S_ADDR);
  assign swrite     = (state_q == S_DATA);
  assign start_step = (state_q == S_RUN);
  assign cread      = (state_q == S_LATCH);
  assign snap_valid = (state_q == S_HOLD);
  assign dac_addr   = addr_write ? DAC_ADDR : 8'h00;
  assign dac_wdata  = swrite ? code_q : 8'h00;
  assign step_idx   = step_idx_q;

`ifdef STEP_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    snap_data = 32'h0;
    unique case (snap_sel)
      3'd0:    snap_data = snap_time_q;
      3'd1:    snap_data = snap_ch1_q;
      3'd2:    snap_data = snap_ch2_q;
      3'd3:    snap_data = snap_ch3_q;
      3'd4:    snap_data = snap_ch4_q;
      default: snap_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_step_scan_ctrl.sv
// Self-checking bench for step_scan_ctrl: table of scan vectors with a DAC-code scoreboard,
// plus hand sequences for zero-step scans, abort, mid-scan reset and the RUN watchdog.
module tb_step_scan_ctrl;

  localparam logic [7:0]  DAC_ADDR = 8'h01;
  localparam logic [31:0] TMO      = 32'd100;

  logic        clk;
  logic        reset_n;
  logic        cfg_start, cfg_abort;
  logic [7:0]  cfg_first_code, cfg_step, cfg_nsteps;
  logic [15:0] cfg_settle;
  logic        stop_step;
  logic [31:0] time_count, ch1_count, ch2_count, ch3_count, ch4_count;
  logic [7:0]  dac_addr, dac_wdata;
  logic        addr_write, swrite, start_step, cread;
  logic [2:0]  snap_sel;
  logic [31:0] snap_data;
  logic        snap_valid, snap_ack, busy, done, timeout_err;
  logic [7:0]  step_idx;

  step_scan_ctrl #(.DAC_ADDR(DAC_ADDR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_first_code(cfg_first_code), .cfg_step(cfg_step), .cfg_nsteps(cfg_nsteps),
    .cfg_settle(cfg_settle), .stop_step(stop_step), .time_count(time_count),
    .ch1_count(ch1_count), .ch2_count(ch2_count), .ch3_count(ch3_count), .ch4_count(ch4_count),
    .dac_addr(dac_addr), .dac_wdata(dac_wdata), .addr_write(addr_write), .swrite(swrite),
    .start_step(start_step), .cread(cread), .snap_sel(snap_sel), .snap_data(snap_data),
    .snap_valid(snap_valid), .snap_ack(snap_ack), .busy(busy), .done(done),
    .step_idx(step_idx), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  first;
    logic [7:0]  step;
    logic [7:0]  nsteps;
    logic [15:0] settle;
    int          stop_dly;
    int          ack_dly;
    logic        inject;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t       vecs [5];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_addr = 0, n_swrite = 0, n_cread = 0, n_done = 0;
  int         swrite_cyc = 0;
  int         exp_settle = 0;
  logic       start_prev = 1'b0;
  logic [7:0] last_code = 8'h00;
  logic [7:0] exp_codes [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'h0, act}, {31'h0, exp});
  endtask

  // Advance one cycle and observe the DUT 1 time unit after the edge; the DAC-code scoreboard lives here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (addr_write) begin
      n_addr++;
      check32("dac_addr", {24'h0, dac_addr}, {24'h0, DAC_ADDR});
    end
    if (swrite) begin
      n_swrite++;
      last_code  = dac_wdata;
      swrite_cyc = cyc;
      if (exp_codes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL swrite_unexpected: got code %h, expected no write", dac_wdata);
      end else begin
        check32("dac_wdata", {24'h0, dac_wdata}, {24'h0, exp_codes.pop_front()});
      end
    end
    if (start_step && !start_prev)
      check32("settle_gap", 32'(cyc - swrite_cyc), 32'(exp_settle + 1));
    start_prev = start_step;
    if (cread) n_cread++;
    if (done)  n_done++;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start_step && n < 500) begin
      tick();
      n++;
    end
    check1("start_step_seen", start_step, 1'b1);
  endtask

  task automatic start_scan(input logic [7:0] first, input logic [7:0] step,
                            input logic [7:0] n, input logic [15:0] settle);
    logic [7:0] c;
    cfg_first_code = first;
    cfg_step       = step;
    cfg_nsteps     = n;
    cfg_settle     = settle;
    exp_settle     = int'(settle);
    c = first;
    for (int i = 0; i < int'(n); i++) begin
      exp_codes.push_back(c);
      c = c + step;
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // abort_mode: 0 none, 1 abort during RUN, 2 abort together with snap_ack in HOLD
  task automatic do_step(input int i, input int stop_dly, input int ack_dly,
                         input logic inject, input int abort_mode);
    logic [31:0] exp_snap [8];
    wait_start();
    stop_step = 1'b1;
    tick();
    stop_step = 1'b0;
    check1("stop_ignored_first_run", start_step, 1'b1);
    if (abort_mode == 1) begin
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check1("abort_run_start_step", start_step, 1'b0);
      check1("abort_run_busy", busy, 1'b0);
      check1("abort_run_done", done, 1'b0);
      return;
    end
    if (inject) begin
      cfg_first_code = 8'hAA;
      cfg_step       = 8'h11;
      cfg_nsteps     = 8'h00;
      cfg_settle     = 16'h0003;
      cfg_start      = 1'b1;
      tick();
      cfg_start      = 1'b0;
      check1("start_ignored_busy", busy & start_step, 1'b1);
    end
    repeat (stop_dly) tick();
    exp_snap[0] = $urandom;
    exp_snap[1] = (i == 0) ? 32'hDEADBEEF : $urandom;
    exp_snap[2] = $urandom;
    exp_snap[3] = $urandom;
    exp_snap[4] = $urandom;
    exp_snap[5] = 32'h0;
    exp_snap[6] = 32'h0;
    exp_snap[7] = 32'h0;
    time_count = exp_snap[0];
    ch1_count  = exp_snap[1];
    ch2_count  = exp_snap[2];
    ch3_count  = exp_snap[3];
    ch4_count  = exp_snap[4];
    stop_step = 1'b1;
    tick();
    stop_step = 1'b0;
    check1("latch_start_step_low", start_step, 1'b0);
    check1("latch_cread", cread, 1'b1);
    tick();
    check1("capt_cread_low", cread, 1'b0);
    tick();
    check1("hold_snap_valid", snap_valid, 1'b1);
    time_count = $urandom;
    ch1_count  = $urandom;
    ch2_count  = $urandom;
    ch3_count  = $urandom;
    ch4_count  = $urandom;
    for (int s = 0; s < 8; s++) begin
      snap_sel = 3'(s);
      #1;
      check32($sformatf("snap_data[%0d]", s), snap_data, exp_snap[s]);
    end
    if (abort_mode == 2) begin
      cfg_abort = 1'b1;
      snap_ack  = 1'b1;
      tick();
      cfg_abort = 1'b0;
      snap_ack  = 1'b0;
      check1("abort_hold_snap_valid", snap_valid, 1'b0);
      check1("abort_hold_busy", busy, 1'b0);
      check32("abort_hold_step_idx", 32'(step_idx), 32'(i));
      return;
    end
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      check1("hold_wait_snap_valid", snap_valid, 1'b1);
      check1("hold_wait_no_addr", addr_write, 1'b0);
    end
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    check1("ack_snap_valid_low", snap_valid, 1'b0);
    check32("step_idx", 32'(step_idx), 32'(i + 1));
  endtask

  task automatic run_vec(input int v);
    int a0, c0, d0;
    a0 = n_addr;
    c0 = n_cread;
    d0 = n_done;
    start_scan(vecs[v].first, vecs[v].step, vecs[v].nsteps, vecs[v].settle);
    check1("start_busy", busy, 1'b1);
    for (int i = 0; i < int'(vecs[v].nsteps); i++)
      do_step(i, vecs[v].stop_dly, vecs[v].ack_dly, vecs[v].inject && (i == 0), 0);
    tick();
    check1("done_pulse", done, 1'b1);
    tick();
    check1("done_one_cycle", done, 1'b0);
    check1("idle_busy", busy, 1'b0);
    check32("cread_count", 32'(n_cread - c0), 32'(vecs[v].nsteps));
    check32("addr_count", 32'(n_addr - a0), 32'(vecs[v].nsteps));
    check32("done_count", 32'(n_done - d0), 32'd1);
    check32("codes_left", 32'(exp_codes.size()), 32'd0);
    check32("last_code", {24'h0, last_code}, {24'h0, vecs[v].exp_last});
    check32("final_step_idx", 32'(step_idx), 32'(vecs[v].nsteps));
    $display("vector %0d: first=%h step=%h n=%0d settle=%0d complete, errors so far %0d",
             v, vecs[v].first, vecs[v].step, vecs[v].nsteps, vecs[v].settle, errors);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int a0, s0, d0;
    vecs[0] = '{8'h10, 8'h04, 8'd3, 16'd5, 18, 0,  1'b1, 8'h18};
    vecs[1] = '{8'hFE, 8'h03, 8'd2, 16'd0, 3,  0,  1'b0, 8'h01};
    vecs[2] = '{8'h33, 8'h00, 8'd2, 16'd1, 1,  10, 1'b0, 8'h33};
    vecs[3] = '{8'h80, 8'h80, 8'd3, 16'd2, 2,  1,  1'b0, 8'h80};
    vecs[4] = '{8'h00, 8'hFF, 8'd1, 16'd0, 1,  3,  1'b0, 8'h00};

    reset_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; stop_step = 1'b0; snap_ack = 1'b0;
    cfg_first_code = 8'h00; cfg_step = 8'h00; cfg_nsteps = 8'h00; cfg_settle = 16'h0;
    time_count = 32'h0; ch1_count = 32'h0; ch2_count = 32'h0; ch3_count = 32'h0; ch4_count = 32'h0;
    snap_sel = 3'd0;
    repeat (3) tick();
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check32("reset_step_idx", 32'(step_idx), 32'd0);
    check32("reset_snap", snap_data, 32'h0);
    check1("reset_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    // Zero-step scan: done one cycle after start, no DAC traffic.
    a0 = n_addr; s0 = n_swrite; d0 = n_done;
    start_scan(8'h12, 8'h01, 8'd0, 16'd4);
    check1("zero_done", done, 1'b1);
    check1("zero_busy", busy, 1'b1);
    tick();
    check1("zero_done_low", done, 1'b0);
    check1("zero_idle", busy, 1'b0);
    check32("zero_addr_count", 32'(n_addr - a0), 32'd0);
    check32("zero_swrite_count", 32'(n_swrite - s0), 32'd0);
    check32("zero_done_count", 32'(n_done - d0), 32'd1);
    $display("zero-step scan complete, errors so far %0d", errors);

    // Abort during RUN of the second step.
    d0 = n_done; s0 = n_swrite;
    start_scan(8'h40, 8'h08, 8'd4, 16'd2);
    do_step(0, 3, 0, 1'b0, 0);
    do_step(1, 3, 0, 1'b0, 1);
    repeat (4) tick();
    check1("abort_stays_idle", busy, 1'b0);
    check32("abort_no_done", 32'(n_done - d0), 32'd0);
    check32("abort_swrite_count", 32'(n_swrite - s0), 32'd2);
    exp_codes.delete();
    $display("abort in RUN complete, errors so far %0d", errors);

    // Abort coincident with snap_ack in HOLD.
    d0 = n_done;
    start_scan(8'h50, 8'h01, 8'd2, 16'd0);
    do_step(0, 2, 0, 1'b0, 2);
    repeat (3) tick();
    check1("abort_hold_idle", busy, 1'b0);
    check32("abort_hold_no_done", 32'(n_done - d0), 32'd0);
    exp_codes.delete();
    $display("abort in HOLD complete, errors so far %0d", errors);

    // Reset while in SETTLE clears outputs and snapshot.
    start_scan(8'h20, 8'h01, 8'd2, 16'd20);
    repeat (4) tick();
    check1("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    tick();
    check32("reset_mid_outputs",
            {18'h0, addr_write, swrite, start_step, cread, snap_valid, busy, done, timeout_err, step_idx},
            32'h0);
    check32("reset_mid_dac", {16'h0, dac_addr, dac_wdata}, 32'h0);
    for (int s = 0; s < 5; s++) begin
      snap_sel = 3'(s);
      #1;
      check32($sformatf("reset_mid_snap[%0d]", s), snap_data, 32'h0);
    end
    reset_n = 1'b1;
    exp_codes.delete();
    tick();
    $display("reset in SETTLE complete, errors so far %0d", errors);

`ifdef STEP_TIMEOUT_EN
    start_scan(8'h05, 8'h01, 8'd1, 16'd0);
    wait_start();
    repeat (99) tick();
    check1("tmo_run_cycle100", start_step, 1'b1);
    tick();
    check1("tmo_busy", busy, 1'b0);
    check1("tmo_start_step", start_step, 1'b0);
    check1("tmo_err_set", timeout_err, 1'b1);
    repeat (3) tick();
    check1("tmo_err_sticky", timeout_err, 1'b1);
    start_scan(8'h05, 8'h01, 8'd0, 16'd0);
    check1("tmo_err_cleared", timeout_err, 1'b0);
    tick();
    $display("timeout scan complete, errors so far %0d", errors);
`else
    start_scan(8'h05, 8'h01, 8'd1, 16'd0);
    wait_start();
    repeat (150) tick();
    check1("long_run_start_step", start_step, 1'b1);
    check1("long_run_no_timeout", timeout_err, 1'b0);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check1("long_run_abort_idle", busy, 1'b0);
    exp_codes.delete();
    $display("long RUN without watchdog complete, errors so far %0d", errors);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_scan_ctrl.md
STEP_SCAN_CTRL -- requirements
Module: step_scan_ctrl

Interface
REQ-001 SHALL have parameter DAC_ADDR, default 8'h01: DAC register address written before each step.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd50_000_000: RUN-state limit, used only with STEP_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port cfg_start  in  1: one-cycle scan start request.
REQ-006 SHALL have port cfg_abort  in  1: abort scan, level sampled every cycle.
REQ-007 SHALL have ports cfg_first_code / cfg_step / cfg_nsteps  in  8 each: first DAC code, code increment, step count.
REQ-008 SHALL have port cfg_settle  in  16: DAC settle cycles.
REQ-009 SHALL have port stop_step  in  1: step finished, from counter.
REQ-010 SHALL have ports time_count, ch1_count..ch4_count  in  32 each: live counter values.
REQ-011 SHALL have ports dac_addr, dac_wdata  out  8; addr_write, swrite, start_step, cread  out  1.
REQ-012 SHALL have ports snap_sel  in  3; snap_data  out  32: 0=time, 1..4=ch1..ch4, others=0.
REQ-013 SHALL have ports snap_valid out 1, snap_ack in 1, busy out 1, done out 1, step_idx out 8, timeout_err out 1.

Function
REQ-014 SHALL implement states IDLE, ADDR, DATA, SETTLE, RUN, LATCH, CAPT, HOLD, NEXT, DONE.
REQ-015 In IDLE, cfg_start SHALL latch all cfg_* inputs, clear step_idx, load code=cfg_first_code, go ADDR; if cfg_nsteps==0 go DONE instead.
REQ-016 cfg_start outside IDLE SHALL be ignored; latched config SHALL not change during a scan.
REQ-017 ADDR: addr_write=1 for exactly one cycle, dac_addr=DAC_ADDR; next DATA.
REQ-018 DATA: swrite=1 for exactly one cycle, dac_wdata=code; next SETTLE.
REQ-019 SETTLE: remain exactly cfg_settle cycles (0 = zero cycles, direct to RUN).
REQ-020 RUN: start_step=1 held; stop_step SHALL be ignored on the first RUN cycle; stop_step=1 thereafter moves to LATCH with start_step=0 that cycle.
REQ-021 LATCH: cread=1 for exactly one cycle; CAPT: copy time_count, ch1..ch4_count into snapshot registers, set snap_valid=1 next cycle.
REQ-022 HOLD: keep snap_valid=1 until snap_ack=1; then clear snap_valid, step_idx+=1, go NEXT.
REQ-023 NEXT: if step_idx==latched nsteps go DONE; else code=code+step modulo 256 (8-bit wrap, no carry) and go ADDR.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 snap_data SHALL be combinational from snapshot registers and snap_sel; snapshot SHALL hold until next CAPT.
REQ-027 cfg_abort=1 in any non-IDLE state SHALL go IDLE next cycle with all strobes, start_step, snap_valid=0; done not asserted; abort beats simultaneous snap_ack or stop_step.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force IDLE, all outputs 0, snapshot registers 0, step_idx 0, code 0, timeout_err 0, including mid-scan.

Configuration
REQ-029 Macro STEP_TIMEOUT_EN defined: RUN lasting TIMEOUT_CYCLES cycles without stop_step SHALL go IDLE, drop start_step, set timeout_err=1 sticky until next accepted cfg_start or reset.
REQ-030 Macro STEP_TIMEOUT_EN undefined: RUN waits indefinitely; timeout_err tied 0; no timeout counter present.

Verification
REQ-031 first=8'h10, step=8'h04, nsteps=3, settle=5, stop_step 20 cycles after start_step, immediate ack -> dac_wdata 10,14,18; three cread pulses; done once; step_idx=3.
REQ-032 first=8'hFE, step=8'h03, nsteps=2 -> dac_wdata FE then 01.
REQ-033 ch1_count=32'hDEADBEEF at CAPT, snap_sel=1 -> snap_data=DEADBEEF; snap_ack delayed 10 cycles -> snap_valid held 10 cycles, no ADDR until ack.
REQ-034 cfg_abort during RUN of step 2 -> IDLE next cycle, start_step=0, busy=0, done never asserted; cfg_nsteps=0 -> done one cycle after cfg_start, no strobes.
REQ-035 With STEP_TIMEOUT_EN, TIMEOUT_CYCLES=100, stop_step held 0 -> timeout_err=1 at cycle 100 of RUN, busy=0; next cfg_start clears it.
REQ-036 reset_n=0 in SETTLE -> all outputs 0 next cycle; cfg_start during busy -> ignored, sequence unchanged.
